// File: rtl/fifo2axis_rr_sched.sv
// Round-robin batch scheduler: grants one producer at a time and drives the shared
// FIFO-to-AXIS loader with a start pulse followed by BATCH_LEN write strobes.
module fifo2axis_rr_sched #(
   parameter int unsigned NUM_SRC    = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BATCH_LEN  = 4,
   parameter int unsigned TIMEOUT    = 1024,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_SRC-1:0]            src_req,
   input  logic [NUM_SRC-1:0]            src_valid,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
   output logic [NUM_SRC-1:0]            src_ready,
   output logic [NUM_SRC-1:0]            src_grant,
   output logic                          ld_start,
   output logic                          ld_write,
   output logic [DATA_WIDTH-1:0]         ld_din,
   input  logic                          acc_tlast,
   output logic                          busy,
   output logic                          batch_done,
   output logic [$clog2(NUM_SRC)-1:0]    batch_src,
   output logic                          timeout_err,
   output logic [CNT_W-1:0]              batch_count
);

   localparam int unsigned SRC_W = $clog2(NUM_SRC);
   localparam int unsigned WC_W  = $clog2(BATCH_LEN + 1);
   localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_START   = 3'd1;
   localparam logic [2:0] S_SETTLE  = 3'd2;
   localparam logic [2:0] S_LOAD    = 3'd3;
   localparam logic [2:0] S_WAIT    = 3'd4;
   localparam logic [2:0] S_RELEASE = 3'd5;

   localparam logic [WC_W-1:0] WC_LAST = WC_W'(BATCH_LEN - 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   logic [2:0]            state_q,       state_d;
   logic [NUM_SRC-1:0]    grant_q,       grant_d;
   logic [SRC_W-1:0]      ptr_q,         ptr_d;
   logic [SRC_W-1:0]      batch_src_q,   batch_src_d;
   logic                  ld_start_q,    ld_start_d;
   logic                  ld_write_q,    ld_write_d;
   logic [DATA_WIDTH-1:0] ld_din_q,      ld_din_d;
   logic [WC_W-1:0]       word_cnt_q,    word_cnt_d;
   logic [TO_W-1:0]       to_cnt_q,      to_cnt_d;
   logic                  batch_done_q,  batch_done_d;
   logic                  timeout_err_q, timeout_err_d;
   logic [CNT_W-1:0]      batch_cnt_q,   batch_cnt_d;

   logic                  pick_found;
   logic [SRC_W-1:0]      pick_idx;
   logic [DATA_WIDTH-1:0] grant_word;
   logic                  xfer;

   // Rotating scan starting just after the last served source, so it drops to lowest priority.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int unsigned i = 1; i <= NUM_SRC; i++) begin
         if (!pick_found && src_req[SRC_W'((32'(ptr_q) + i) % NUM_SRC)]) begin
            pick_found = 1'b1;
            pick_idx   = SRC_W'((32'(ptr_q) + i) % NUM_SRC);
         end
      end
   end

   always_comb begin
      grant_word = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (grant_q[i]) grant_word = src_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign src_ready = grant_q & {NUM_SRC{state_q == S_LOAD}};
   assign xfer      = |(src_valid & src_ready);

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      ptr_d         = ptr_q;
      batch_src_d   = batch_src_q;
      ld_start_d    = 1'b0;
      ld_write_d    = 1'b0;
      ld_din_d      = ld_din_q;
      word_cnt_d    = word_cnt_q;
      to_cnt_d      = to_cnt_q;
      batch_done_d  = 1'b0;
      timeout_err_d = 1'b0;
      batch_cnt_d   = batch_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               grant_d     = NUM_SRC'(1) << pick_idx;
               batch_src_d = pick_idx;
               ptr_d       = pick_idx;
               ld_start_d  = 1'b1;
               state_d     = S_START;
            end
         end
         S_START: state_d = S_SETTLE;
         S_SETTLE: begin
            word_cnt_d = '0;
            state_d    = S_LOAD;
         end
         S_LOAD: begin
            if (xfer) begin
               ld_write_d = 1'b1;
               ld_din_d   = grant_word;
               word_cnt_d = word_cnt_q + 1'b1;
               if (word_cnt_q == WC_LAST) begin
                  to_cnt_d = '0;
                  state_d  = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            to_cnt_d = to_cnt_q + 1'b1;
            // Completion takes precedence over a coincident timeout.
            if (acc_tlast) begin
               batch_done_d = 1'b1;
               batch_cnt_d  = batch_cnt_q + 1'b1;
               state_d      = S_RELEASE;
            end else if (to_cnt_q == TO_LAST) begin
               timeout_err_d = 1'b1;
               state_d       = S_RELEASE;
            end
         end
         S_RELEASE: begin
            grant_d  = '0;
            to_cnt_d = '0;
            state_d  = S_IDLE;
         end
         default: begin
            grant_d = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         grant_q       <= '0;
         ptr_q         <= SRC_W'(NUM_SRC - 1);
         batch_src_q   <= '0;
         ld_start_q    <= 1'b0;
         ld_write_q    <= 1'b0;
         ld_din_q      <= '0;
         word_cnt_q    <= '0;
         to_cnt_q      <= '0;
         batch_done_q  <= 1'b0;
         timeout_err_q <= 1'b0;
         batch_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         ptr_q         <= ptr_d;
         batch_src_q   <= batch_src_d;
         ld_start_q    <= ld_start_d;
         ld_write_q    <= ld_write_d;
         ld_din_q      <= ld_din_d;
         word_cnt_q    <= word_cnt_d;
         to_cnt_q      <= to_cnt_d;
         batch_done_q  <= batch_done_d;
         timeout_err_q <= timeout_err_d;
         batch_cnt_q   <= batch_cnt_d;
      end
   end

   assign src_grant   = grant_q;
   assign ld_start    = ld_start_q;
   assign ld_write    = ld_write_q;
   assign ld_din      = ld_din_q;
   assign busy        = (state_q != S_IDLE);
   assign batch_done  = batch_done_q;
   assign batch_src   = batch_src_q;
   assign timeout_err = timeout_err_q;
   assign batch_count = batch_cnt_q;

endmodule

// File: tb/tb_fifo2axis_rr_sched.sv
// Directed bench for fifo2axis_rr_sched: hand-timed batches, RR order, stall gap,
// timeout, async reset mid-batch, stray tlast and counter wrap (CNT_W=4, TIMEOUT=16).
module tb_fifo2axis_rr_sched;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [3:0]   src_req = '0;
   logic [3:0]   src_valid = '0;
   logic [127:0] src_data = '0;
   logic [3:0]   src_ready;
   logic [3:0]   src_grant;
   logic         ld_start;
   logic         ld_write;
   logic [31:0]  ld_din;
   logic         acc_tlast = 1'b0;
   logic         busy;
   logic         batch_done;
   logic [1:0]   batch_src;
   logic         timeout_err;
   logic [3:0]   batch_count;

   int total = 0;
   int bad   = 0;
   logic [3:0] exp_cnt = '0;

   fifo2axis_rr_sched #(
      .NUM_SRC(4), .DATA_WIDTH(32), .BATCH_LEN(4), .TIMEOUT(16), .CNT_W(4)
   ) dut (
      .clk(clk), .rst(rst), .src_req(src_req), .src_valid(src_valid),
      .src_data(src_data), .src_ready(src_ready), .src_grant(src_grant),
      .ld_start(ld_start), .ld_write(ld_write), .ld_din(ld_din),
      .acc_tlast(acc_tlast), .busy(busy), .batch_done(batch_done),
      .batch_src(batch_src), .timeout_err(timeout_err), .batch_count(batch_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_grant"}, src_grant, 4'b0000);
      chk({tag, "_ready"}, src_ready, 4'b0000);
      chk({tag, "_start"}, ld_start, 1'b0);
      chk({tag, "_write"}, ld_write, 1'b0);
      chk({tag, "_din"}, ld_din, 32'h0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, batch_done, 1'b0);
      chk({tag, "_terr"}, timeout_err, 1'b0);
      chk({tag, "_bsrc"}, batch_src, 2'd0);
      chk({tag, "_cnt"}, batch_count, 4'd0);
   endtask

   // Caller leaves src_req set and the DUT in IDLE; returns in IDLE after RELEASE.
   task automatic do_batch(input int src, input logic [31:0] base, input int gap,
                           input int wait_cyc, input bit tlast_ok, input bit noise);
      logic [3:0] oh;
      oh = 4'b0001 << src;
      tick();
      chk("grant", src_grant, oh);
      chk("bsrc", batch_src, src);
      chk("start_hi", ld_start, 1'b1);
      chk("busy_start", busy, 1'b1);
      tick();
      chk("start_lo", ld_start, 1'b0);
      chk("ready_settle", src_ready, 4'b0000);
      tick();
      chk("ready_load", src_ready, oh);
      for (int w = 0; w < 4; w++) begin
         src_data[src*32 +: 32] = base + w;
         src_valid[src] = 1'b1;
         acc_tlast = noise;
         tick();
         chk("write", ld_write, 1'b1);
         chk("din", ld_din, base + w);
         chk("no_done_load", batch_done, 1'b0);
         if (w == 1 && gap > 0) begin
            src_valid[src] = 1'b0;
            for (int g = 0; g < gap; g++) begin
               tick();
               chk("gap_write", ld_write, 1'b0);
               chk("gap_ready", src_ready, oh);
            end
         end
      end
      src_valid = '0;
      acc_tlast = 1'b0;
      for (int c = 0; c < wait_cyc; c++) begin
         tick();
         chk("wait_write", ld_write, 1'b0);
         chk("wait_done", batch_done, 1'b0);
         chk("wait_terr", timeout_err, 1'b0);
         chk("wait_busy", busy, 1'b1);
      end
      if (tlast_ok) begin
         acc_tlast = 1'b1;
         tick();
         acc_tlast = 1'b0;
         exp_cnt = exp_cnt + 1'b1;
         chk("done", batch_done, 1'b1);
         chk("terr_lo", timeout_err, 1'b0);
      end else begin
         tick();
         chk("terr", timeout_err, 1'b1);
         chk("done_lo", batch_done, 1'b0);
      end
      chk("count", batch_count, exp_cnt);
      chk("grant_release", src_grant, oh);
      tick();
      chk("busy_idle", busy, 1'b0);
      chk("grant_idle", src_grant, 4'b0000);
      chk("done_idle", batch_done, 1'b0);
      chk("terr_idle", timeout_err, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      exp_cnt = '0;
   endtask

   initial begin
      do_reset();
      chk_idle_outputs("rst0");

      // Single source 2, tlast in third WAIT_DONE cycle.
      src_req = 4'b0100;
      do_batch(2, 32'hA0, 0, 2, 1'b1, 1'b0);
      src_req = 4'b0000;
      tick();
      chk("idle_quiet", busy, 1'b0);

      // Async reset while source 1 is mid-LOAD after two words.
      src_req = 4'b0010;
      tick();
      chk("r_grant", src_grant, 4'b0010);
      tick();
      tick();
      src_data[63:32] = 32'h55;
      src_valid = 4'b0010;
      tick();
      tick();
      chk("r_write", ld_write, 1'b1);
      #3;
      rst = 1'b1;
      #1;
      chk_idle_outputs("rst_async");
      src_valid = '0;
      tick();
      rst = 1'b0;
      exp_cnt = '0;
      chk_idle_outputs("rst_rel");

      // Round robin over 0,1,3 with a stall gap and stray tlast during LOAD.
      src_req = 4'b1011;
      do_batch(0, 32'h100, 0, 0, 1'b1, 1'b0);
      do_batch(1, 32'h200, 5, 1, 1'b1, 1'b0);
      do_batch(3, 32'h300, 0, 2, 1'b1, 1'b1);
      do_batch(0, 32'h110, 0, 0, 1'b1, 1'b0);
      do_batch(1, 32'h210, 0, 3, 1'b1, 1'b0);
      do_batch(3, 32'h310, 0, 1, 1'b1, 1'b0);
      chk("count_six", batch_count, 4'd6);

      // Stray tlast while IDLE.
      src_req = 4'b0000;
      acc_tlast = 1'b1;
      tick();
      tick();
      acc_tlast = 1'b0;
      chk("idle_tlast_done", batch_done, 1'b0);
      chk("idle_tlast_busy", busy, 1'b0);
      chk("idle_tlast_cnt", batch_count, 4'd6);

      // Timeout on source 0, then source 2 is served next.
      src_req = 4'b0101;
      do_batch(0, 32'h400, 0, 15, 1'b0, 1'b0);
      do_batch(2, 32'h500, 0, 0, 1'b1, 1'b0);

      // Wrap the 4-bit completed-batch counter.
      src_req = 4'b1000;
      for (int b = 0; b < 9; b++) begin
         do_batch(3, 32'h600 + 32'(b * 16), 0, 0, 1'b1, 1'b0);
      end
      chk("count_wrap", batch_count, 4'd0);
      src_req = 4'b0000;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo2axis_rr_sched.md
Name: fifo2axis_rr_sched

Overview:
- Round-robin batch scheduler that shares one FIFO-to-AXIS loader and its HLS accelerator among NUM_SRC word producers.
- Grants one source at a time and sequences the loader: one start pulse, then BATCH_LEN write strobes carrying that source's words.
- After the batch, waits for the accelerator's tlast before arbitrating again.
- Sits between the producer blocks and the loader's start/write/din inputs.

Parameters:
- NUM_SRC, 4, number of requesters (2..8).
- DATA_WIDTH, 32, word width.
- BATCH_LEN, 4, words per batch; must equal the loader buffer depth.
- TIMEOUT, 1024, maximum cycles in WAIT_DONE before the batch is abandoned.
- CNT_W, 16, width of the completed-batch counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- src_req  in  NUM_SRC  per-source batch request (level).
- src_valid  in  NUM_SRC  per-source word valid.
- src_data  in  NUM_SRC*DATA_WIDTH  packed words; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- src_ready  out  NUM_SRC  word accept; combinational: src_grant & {NUM_SRC{state==LOAD}}.
- src_grant  out  NUM_SRC  one-hot grant, registered.
- ld_start  out  1  start pulse to the loader, registered.
- ld_write  out  1  write strobe to the loader, registered.
- ld_din  out  DATA_WIDTH  write data to the loader, registered.
- acc_tlast  in  1  accelerator end-of-batch indication.
- busy  out  1  high in every state except IDLE.
- batch_done  out  1  one-cycle pulse when a batch completes.
- batch_src  out  clog2(NUM_SRC)  index of the last granted source; updated at grant.
- timeout_err  out  1  one-cycle pulse when a batch is abandoned.
- batch_count  out  CNT_W  completed batches; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async): state IDLE.
  - src_grant, ld_start, ld_write, ld_din, batch_done, timeout_err, batch_count, batch_src, word counter and timeout counter all 0.
  - RR pointer = NUM_SRC-1, so source 0 has first priority.
  - Reset mid-batch drops the grant immediately; no partial-batch recovery.
- States: IDLE, START, SETTLE, LOAD, WAIT_DONE, RELEASE.
- IDLE, if |src_req:
  - Pick the first requester scanning ptr+1, ptr+2, ... modulo NUM_SRC.
  - Register src_grant, batch_src and ptr.
  - Go to START.
- START: ld_start=1 for exactly this cycle. Go to SETTLE.
- SETTLE: one idle cycle so the loader is in its write state before the first strobe. Word counter=0. Go to LOAD.
- LOAD:
  - A transfer occurs when src_valid[g] & src_ready[g].
  - On transfer, next cycle ld_write=1 and ld_din=word.
  - Transfers may be back-to-back, one per cycle; src_valid low stalls with no timeout.
  - The word counter increments per transfer.
  - The transfer with counter==BATCH_LEN-1 moves to WAIT_DONE; ld_write for that word still appears in the first WAIT_DONE cycle.
- WAIT_DONE:
  - Timeout counter increments each cycle.
  - acc_tlast=1: batch_done pulses next cycle, batch_count+1, go to RELEASE.
  - Else counter==TIMEOUT-1: timeout_err pulses next cycle, batch_count unchanged, go to RELEASE.
  - acc_tlast and timeout in the same cycle: completion wins.
- RELEASE: src_grant cleared, timeout counter cleared. Go to IDLE. This guarantees at least one grant-free cycle between batches.
- Once granted, a batch always runs to completion: deassertion of src_req mid-batch is ignored, and other sources' requests wait.
- acc_tlast outside WAIT_DONE is ignored.
- src_req of the just-served source is eligible again, but at lowest priority.
- Throughput: minimum batch cost is 1 (IDLE) + 1 (START) + 1 (SETTLE) + BATCH_LEN + WAIT_DONE length + 1 (RELEASE) cycles.

Test Plan:
- Single source 2 requests, data 0xA0..0xA3 always valid, acc_tlast 3 cycles after entering WAIT_DONE:
  - src_grant=4'b0100 and one ld_start pulse.
  - Four consecutive ld_write with ld_din 0xA0,0xA1,0xA2,0xA3.
  - Then batch_done pulse, batch_count=1, busy low two cycles later.
- Sources 0,1,3 request continuously, each batch completed by acc_tlast:
  - Grant order 0,1,3,0,1,3.
  - batch_src 0,1,3,...
  - batch_count=6 after six batches.
- Granted source drops src_valid for 5 cycles after word 1: src_ready held high, no ld_write during the gap, remaining words delivered in order, total still 4 strobes.
- acc_tlast never asserted, TIMEOUT=16: after 16 WAIT_DONE cycles, one timeout_err pulse; batch_count unchanged; the next requester is granted.
- rst asserted during LOAD after 2 words: all outputs 0 asynchronously; after release, source 0 served first with a fresh start pulse.
- acc_tlast pulsed while IDLE and during LOAD: no batch_done, no state change; batch_count wraps 0xFFFF->0x0000 when preloaded by a run of 65536 batches (or CNT_W=4, 16 batches).
